// File: rtl/cache_refill_arbiter_pkg.sv
// Shared constants, state and owner encodings for the cache refill arbiter.
//   MEM_ADDR_W / MEM_BEAT_W / LINE_BEATS  default geometry (32-bit addr, 8 x 32-bit beats)
//   LINE_BITS / LINE_OFFSET_W             256-bit line, 5 byte-offset bits
//   state_e                               one-hot FSM encoding
//   owner_e                               which cache owns the current refill
//   rr_pick()                             round-robin grant decision
package cache_refill_arbiter_pkg;

  localparam int MEM_ADDR_W    = 32;
  localparam int MEM_BEAT_W    = 32;
  localparam int LINE_BEATS    = 8;
  localparam int LINE_BITS     = MEM_BEAT_W * LINE_BEATS;
  localparam int LINE_OFFSET_W = $clog2(LINE_BITS / 8);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_ADDR   = 4'b0010,
    S_DATA   = 4'b0100,
    S_RETURN = 4'b1000
  } state_e;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } owner_e;

  // req[0] = icache, req[1] = dcache. On a tie the cache not granted last wins.
  function automatic owner_e rr_pick(input logic [1:0] req, input owner_e last);
    if (req == 2'b11) return (last == ICACHE) ? DCACHE : ICACHE;
    else if (req[1])  return DCACHE;
    else              return ICACHE;
  endfunction

endpackage

// File: rtl/cache_refill_arbiter_refill_line_assembler.sv
// Collects BEATS memory beats into one cache line and checks the last marker.
//   clk, reset   clock, synchronous active-high reset (clears count and line)
//   start        restart beat counter for a new burst
//   capture      beats are accepted only while high (DATA phase)
//   beat_valid / beat_data / beat_last   incoming memory beat
//   line         assembled line, beat0 in the low bits
//   done         combinational: final beat accepted this cycle
//   err          registered 1-cycle pulse, at most one per burst
module refill_line_assembler
  import cache_refill_arbiter_pkg::*;
#(
  parameter int BEAT_W = MEM_BEAT_W,
  parameter int BEATS  = LINE_BEATS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          capture,
  input  logic                          beat_valid,
  input  logic [BEAT_W-1:0]             beat_data,
  input  logic                          beat_last,
  output logic [BEATS-1:0][BEAT_W-1:0]  line,
  output logic                          done,
  output logic                          err
);

  localparam int CNT_W = $clog2(BEATS);

  logic [CNT_W-1:0]            cnt_q;
  logic                        err_seen_q;
  logic                        err_q;
  logic [BEATS-1:0][BEAT_W-1:0] line_q;
  logic [BEATS-1:0]            we;
  logic                        take;
  logic                        is_final;
  logic                        mismatch;

  assign take     = capture & beat_valid;
  assign is_final = (cnt_q == CNT_W'(BEATS - 1));
  // Last marker must appear exactly on the final beat; either an early or
  // a missing marker counts, but only the first one per burst is reported.
  assign mismatch = take & (beat_last != is_final);
  assign done     = take & is_final;

  generate
    for (genvar b = 0; b < BEATS; b++) begin : g_we
      assign we[b] = take && (cnt_q == CNT_W'(b));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      err_seen_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= mismatch & ~err_seen_q;
      if (start) begin
        cnt_q      <= '0;
        err_seen_q <= 1'b0;
      end else if (take) begin
        cnt_q <= cnt_q + 1'b1;
        if (mismatch) err_seen_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= '0;
    end else begin
      for (int b = 0; b < BEATS; b++)
        if (we[b]) line_q[b] <= beat_data;
    end
  end

  assign line = line_q;
  assign err  = err_q;

endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one memory read-burst channel between icache and dcache refills.
// Round-robin grant, one refill in flight, 8-beat aligned burst assembled
// into a 256-bit line and handed back on the owner's return port.
//   clk, reset                         clock, synchronous active-high reset
//   {i,d}cache_read_mem_en/_addr       refill request + physical address
//   mem_ready_for_{i,d}cache_read      arbiter idle
//   mem_receive_{i,d}cache_read_ok     1-cycle grant pulse
//   mem_{i,d}cache_return_data_en/_data line return (data 0 when not returning)
//   {i,d}cache_receive_mem_data_ok     cache consumed the line
//   rd_req/rd_addr/rd_addr_ok          burst address channel
//   rd_data_valid/rd_data/rd_data_last burst data channel
//   refill_err                         last-marker mismatch pulse
module cache_refill_arbiter
  import cache_refill_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int BEAT_W = MEM_BEAT_W,
  parameter int BEATS  = LINE_BEATS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     icache_read_mem_en,
  input  logic [ADDR_W-1:0]        icache_read_mem_addr,
  output logic                     mem_ready_for_icache_read,
  output logic                     mem_receive_icache_read_ok,
  output logic                     mem_icache_return_data_en,
  output logic [BEAT_W*BEATS-1:0]  mem_icache_return_data,
  input  logic                     icache_receive_mem_data_ok,
  input  logic                     dcache_read_mem_en,
  input  logic [ADDR_W-1:0]        dcache_read_mem_addr,
  output logic                     mem_ready_for_dcache_read,
  output logic                     mem_receive_dcache_read_ok,
  output logic                     mem_dcache_return_data_en,
  output logic [BEAT_W*BEATS-1:0]  mem_dcache_return_data,
  input  logic                     dcache_receive_mem_data_ok,
  output logic                     rd_req,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_addr_ok,
  input  logic                     rd_data_valid,
  input  logic [BEAT_W-1:0]        rd_data,
  input  logic                     rd_data_last,
  output logic                     refill_err
);

  localparam int LINE_W = BEAT_W * BEATS;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

  state_e              state_q, state_d;
  owner_e              owner_q, rr_last_q, win;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          req;
  logic                grant;
  logic                rdy;
  logic                asm_start;
  logic                asm_capture;
  logic                asm_done;
  logic                ret_en;
  logic                own_rcv_ok;
  logic [BEATS-1:0][BEAT_W-1:0] line;
  logic [LINE_W-1:0]   line_flat;

  assign req        = {dcache_read_mem_en, icache_read_mem_en};
  assign own_rcv_ok = (owner_q == ICACHE) ? icache_receive_mem_data_ok
                                          : dcache_receive_mem_data_ok;
  assign line_flat  = line;

  // Next-state and control; while reset is high every output stays low.
  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    win         = rr_last_q;
    rdy         = 1'b0;
    rd_req      = 1'b0;
    asm_start   = 1'b0;
    asm_capture = 1'b0;
    ret_en      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          rdy = 1'b1;
          if (|req) begin
            grant   = 1'b1;
            win     = rr_pick(req, rr_last_q);
            state_d = S_ADDR;
          end
        end
        S_ADDR: begin
          rd_req = 1'b1;
          if (rd_addr_ok) begin
            asm_start = 1'b1;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          asm_capture = 1'b1;
          if (asm_done) state_d = S_RETURN;
        end
        S_RETURN: begin
          ret_en = 1'b1;
          if (own_rcv_ok) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= ICACHE;
      rr_last_q <= DCACHE;
      addr_q    <= '0;
    end else if (grant) begin
      owner_q   <= win;
      rr_last_q <= win;
      addr_q    <= ((win == ICACHE) ? icache_read_mem_addr : dcache_read_mem_addr) & ALIGN_MASK;
    end
  end

  refill_line_assembler #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS)
  ) u_asm (
    .clk        (clk),
    .reset      (reset),
    .start      (asm_start),
    .capture    (asm_capture),
    .beat_valid (rd_data_valid),
    .beat_data  (rd_data),
    .beat_last  (rd_data_last),
    .line       (line),
    .done       (asm_done),
    .err        (refill_err)
  );

  assign rd_addr = rd_req ? addr_q : '0;

  assign mem_ready_for_icache_read  = rdy;
  assign mem_ready_for_dcache_read  = rdy;
  assign mem_receive_icache_read_ok = grant & (win == ICACHE);
  assign mem_receive_dcache_read_ok = grant & (win == DCACHE);
  assign mem_icache_return_data_en  = ret_en & (owner_q == ICACHE);
  assign mem_dcache_return_data_en  = ret_en & (owner_q == DCACHE);
  assign mem_icache_return_data     = mem_icache_return_data_en ? line_flat : '0;
  assign mem_dcache_return_data     = mem_dcache_return_data_en ? line_flat : '0;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
module tb_cache_refill_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         icache_read_mem_en, dcache_read_mem_en;
  logic [31:0]  icache_read_mem_addr, dcache_read_mem_addr;
  logic         mem_ready_for_icache_read, mem_ready_for_dcache_read;
  logic         mem_receive_icache_read_ok, mem_receive_dcache_read_ok;
  logic         mem_icache_return_data_en, mem_dcache_return_data_en;
  logic [255:0] mem_icache_return_data, mem_dcache_return_data;
  logic         icache_receive_mem_data_ok, dcache_receive_mem_data_ok;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         rd_addr_ok, rd_data_valid, rd_data_last;
  logic [31:0]  rd_data;
  logic         refill_err;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int ret_i = 0, ret_d = 0, errp = 0;

  cache_refill_arbiter dut (
    .clk                        (clk),
    .reset                      (reset),
    .icache_read_mem_en         (icache_read_mem_en),
    .icache_read_mem_addr       (icache_read_mem_addr),
    .mem_ready_for_icache_read  (mem_ready_for_icache_read),
    .mem_receive_icache_read_ok (mem_receive_icache_read_ok),
    .mem_icache_return_data_en  (mem_icache_return_data_en),
    .mem_icache_return_data     (mem_icache_return_data),
    .icache_receive_mem_data_ok (icache_receive_mem_data_ok),
    .dcache_read_mem_en         (dcache_read_mem_en),
    .dcache_read_mem_addr       (dcache_read_mem_addr),
    .mem_ready_for_dcache_read  (mem_ready_for_dcache_read),
    .mem_receive_dcache_read_ok (mem_receive_dcache_read_ok),
    .mem_dcache_return_data_en  (mem_dcache_return_data_en),
    .mem_dcache_return_data     (mem_dcache_return_data),
    .dcache_receive_mem_data_ok (dcache_receive_mem_data_ok),
    .rd_req                     (rd_req),
    .rd_addr                    (rd_addr),
    .rd_addr_ok                 (rd_addr_ok),
    .rd_data_valid              (rd_data_valid),
    .rd_data                    (rd_data),
    .rd_data_last               (rd_data_last),
    .refill_err                 (refill_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse/cycle monitors sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_icache_return_data_en === 1'b1) ret_i <= ret_i + 1;
    if (mem_dcache_return_data_en === 1'b1) ret_d <= ret_d + 1;
    if (refill_err === 1'b1)                errp  <= errp + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the first ADDR cycle; leaves the DUT in its first DATA cycle.
  task automatic addr_phase(input string tag, input logic [31:0] exp_addr, input int delay);
    bit stable = 1'b1;
    chk({tag, ":rd_req"}, 256'(rd_req), 256'd1);
    for (int i = 0; i < delay; i++) begin
      rd_addr_ok = 1'b0;
      #1;
      if (rd_addr !== exp_addr || rd_req !== 1'b1) stable = 1'b0;
      step();
    end
    rd_addr_ok = 1'b1;
    #1;
    chk({tag, ":rd_addr"}, 256'(rd_addr), 256'(exp_addr));
    chk({tag, ":addr_stable"}, 256'(stable), 256'd1);
    step();
    rd_addr_ok = 1'b0;
  endtask

  task automatic beats(input logic [31:0] base, input logic [31:0] mul,
                       input bit gapped, input int last_at, input int n);
    for (int k = 0; k < n; k++) begin
      if (gapped && k > 0) begin
        rd_data_valid = 1'b0;
        rd_data       = 32'hBAD0_0000;
        rd_data_last  = 1'b1;
        step();
      end
      rd_data_valid = 1'b1;
      rd_data       = base + mul * 32'(k);
      rd_data_last  = (k == last_at);
      step();
    end
    rd_data_valid = 1'b0;
    rd_data_last  = 1'b0;
    rd_data       = '0;
  endtask

  // Called in the first RETURN cycle; consumes the line after `hold` cycles.
  task automatic ret_check(input string tag, input bit is_i, input logic [255:0] exp, input int hold);
    #1;
    chk({tag, ":en"},       256'(is_i ? mem_icache_return_data_en : mem_dcache_return_data_en), 256'd1);
    chk({tag, ":other_en"}, 256'(is_i ? mem_dcache_return_data_en : mem_icache_return_data_en), 256'd0);
    chk({tag, ":line"},       is_i ? mem_icache_return_data : mem_dcache_return_data, exp);
    chk({tag, ":other_line"}, is_i ? mem_dcache_return_data : mem_icache_return_data, 256'd0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, ":en_held"},   256'(is_i ? mem_icache_return_data_en : mem_dcache_return_data_en), 256'd1);
      chk({tag, ":line_held"}, is_i ? mem_icache_return_data : mem_dcache_return_data, exp);
    end
    if (is_i) icache_receive_mem_data_ok = 1'b1;
    else      dcache_receive_mem_data_ok = 1'b1;
    step();
    icache_receive_mem_data_ok = 1'b0;
    dcache_receive_mem_data_ok = 1'b0;
    #1;
    chk({tag, ":en_dropped"}, 256'(is_i ? mem_icache_return_data_en : mem_dcache_return_data_en), 256'd0);
    chk({tag, ":idle_ready"}, 256'(mem_ready_for_icache_read), 256'd1);
  endtask

  int t0, e0, r0, ri0, rd0;

  initial begin
    reset = 1'b1;
    icache_read_mem_en = 0; dcache_read_mem_en = 0;
    icache_read_mem_addr = 0; dcache_read_mem_addr = 0;
    icache_receive_mem_data_ok = 0; dcache_receive_mem_data_ok = 0;
    rd_addr_ok = 0; rd_data_valid = 0; rd_data = 0; rd_data_last = 0;
    step(); step();

    // Reset state
    chk("rst:rd_req",  256'(rd_req), 256'd0);
    chk("rst:ret_en",  256'({mem_icache_return_data_en, mem_dcache_return_data_en}), 256'd0);
    chk("rst:err",     256'(refill_err), 256'd0);
    reset = 1'b0;
    #1;
    chk("rst:ready",   256'({mem_ready_for_icache_read, mem_ready_for_dcache_read}), 256'd3);

    // 1: dcache alone, best-case latency, return held until receive_ok
    e0 = errp;
    dcache_read_mem_en = 1'b1; dcache_read_mem_addr = 32'h0000_1234;
    #1;
    chk("t1:d_grant", 256'(mem_receive_dcache_read_ok), 256'd1);
    chk("t1:i_grant", 256'(mem_receive_icache_read_ok), 256'd0);
    t0 = cyc;
    step();
    dcache_read_mem_en = 1'b0;
    chk("t1:busy", 256'(mem_ready_for_dcache_read), 256'd0);
    addr_phase("t1", 32'h0000_1220, 0);
    beats(32'h0, 32'h1111_1111, 1'b0, 7, 8);
    chk("t1:latency", 256'(cyc - t0), 256'd10);
    ret_check("t1", 1'b0,
      256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_00000000, 2);
    chk("t1:no_err", 256'(errp - e0), 256'd0);

    // 2: simultaneous requests after reset -> icache first, then dcache
    reset = 1'b1; step(); reset = 1'b0;
    icache_read_mem_en = 1'b1; icache_read_mem_addr = 32'h0000_103C;
    dcache_read_mem_en = 1'b1; dcache_read_mem_addr = 32'h0000_2040;
    #1;
    chk("t2:i_grant", 256'(mem_receive_icache_read_ok), 256'd1);
    chk("t2:d_wait",  256'(mem_receive_dcache_read_ok), 256'd0);
    step();
    icache_read_mem_en = 1'b0;
    chk("t2:no_grant_busy", 256'(mem_receive_dcache_read_ok), 256'd0);
    addr_phase("t2i", 32'h0000_1020, 1);
    beats(32'h1000_0000, 32'h1, 1'b0, 7, 8);
    ret_check("t2i", 1'b1,
      256'h10000007_10000006_10000005_10000004_10000003_10000002_10000001_10000000, 0);
    chk("t2:d_grant", 256'(mem_receive_dcache_read_ok), 256'd1);
    step();
    dcache_read_mem_en = 1'b0;
    addr_phase("t2d", 32'h0000_2040, 0);
    beats(32'h2000_0000, 32'h1, 1'b0, 7, 8);
    ret_check("t2d", 1'b0,
      256'h20000007_20000006_20000005_20000004_20000003_20000002_20000001_20000000, 1);
    // rr_last is dcache now: a tie must go to icache
    icache_read_mem_en = 1'b1; icache_read_mem_addr = 32'hDEAD_BEEF;
    dcache_read_mem_en = 1'b1; dcache_read_mem_addr = 32'h0000_5000;
    #1;
    chk("t2:rr_i", 256'(mem_receive_icache_read_ok), 256'd1);
    chk("t2:rr_d", 256'(mem_receive_dcache_read_ok), 256'd0);
    step();
    icache_read_mem_en = 1'b0; dcache_read_mem_en = 1'b0;

    // 3: delayed rd_addr_ok, gapped beats
    addr_phase("t3", 32'hDEAD_BEE0, 5);
    beats(32'hA000_0000, 32'h1, 1'b1, 7, 8);
    ret_check("t3", 1'b1,
      256'hA0000007_A0000006_A0000005_A0000004_A0000003_A0000002_A0000001_A0000000, 0);

    // 4: early last on beat 3 -> one error pulse, burst still ends at beat 7
    dcache_read_mem_en = 1'b1; dcache_read_mem_addr = 32'h0000_0400;
    #1;
    chk("t4:d_grant", 256'(mem_receive_dcache_read_ok), 256'd1);
    step();
    dcache_read_mem_en = 1'b0;
    e0 = errp;
    addr_phase("t4", 32'h0000_0400, 0);
    beats(32'hB000_0000, 32'h1, 1'b0, 3, 8);
    ret_check("t4", 1'b0,
      256'hB0000007_B0000006_B0000005_B0000004_B0000003_B0000002_B0000001_B0000000, 0);
    chk("t4:err_pulses", 256'(errp - e0), 256'd1);

    // 5: reset during beat 4, stray beats ignored, then a clean refill
    icache_read_mem_en = 1'b1; icache_read_mem_addr = 32'h0000_8000;
    #1;
    chk("t5:i_grant", 256'(mem_receive_icache_read_ok), 256'd1);
    step();
    icache_read_mem_en = 1'b0;
    r0 = ret_i;
    addr_phase("t5", 32'h0000_8000, 0);
    beats(32'hC000_0000, 32'h1, 1'b0, 7, 4);
    rd_data_valid = 1'b1; rd_data = 32'hC000_0004; reset = 1'b1;
    step();
    reset = 1'b0;
    rd_data = 32'hFFFF_FFFF; rd_data_last = 1'b1;
    #1;
    chk("t5:idle_ready", 256'({mem_ready_for_icache_read, mem_ready_for_dcache_read}), 256'd3);
    chk("t5:no_rd_req",  256'(rd_req), 256'd0);
    step(); step();
    rd_data_valid = 1'b0; rd_data_last = 1'b0; rd_data = '0;
    #1;
    chk("t5:no_return", 256'(ret_i - r0), 256'd0);
    icache_read_mem_en = 1'b1; icache_read_mem_addr = 32'h0000_8010;
    #1;
    chk("t5:regrant", 256'(mem_receive_icache_read_ok), 256'd1);
    step();
    icache_read_mem_en = 1'b0;
    addr_phase("t5b", 32'h0000_8000, 0);
    beats(32'hC100_0000, 32'h1, 1'b0, 7, 8);
    ret_check("t5b", 1'b1,
      256'hC1000007_C1000006_C1000005_C1000004_C1000003_C1000002_C1000001_C1000000, 0);

    // 6: receive_ok held high -> 1-cycle return, owners alternate
    ri0 = ret_i; rd0 = ret_d;
    icache_receive_mem_data_ok = 1'b1; dcache_receive_mem_data_ok = 1'b1;
    icache_read_mem_en = 1'b1; icache_read_mem_addr = 32'h0000_4000;
    dcache_read_mem_en = 1'b1; dcache_read_mem_addr = 32'h0000_3000;
    #1;
    chk("t6:d_first", 256'(mem_receive_dcache_read_ok), 256'd1);
    chk("t6:i_waits", 256'(mem_receive_icache_read_ok), 256'd0);
    step();
    addr_phase("t6d", 32'h0000_3000, 0);
    beats(32'hD000_0000, 32'h1, 1'b0, 7, 8);
    #1;
    chk("t6d:en",   256'(mem_dcache_return_data_en), 256'd1);
    chk("t6d:line", mem_dcache_return_data,
      256'hD0000007_D0000006_D0000005_D0000004_D0000003_D0000002_D0000001_D0000000);
    step();
    chk("t6d:en_off",  256'(mem_dcache_return_data_en), 256'd0);
    chk("t6:i_next",   256'(mem_receive_icache_read_ok), 256'd1);
    step();
    addr_phase("t6i", 32'h0000_4000, 0);
    beats(32'hE000_0000, 32'h1, 1'b0, 7, 8);
    #1;
    chk("t6i:en",   256'(mem_icache_return_data_en), 256'd1);
    chk("t6i:line", mem_icache_return_data,
      256'hE0000007_E0000006_E0000005_E0000004_E0000003_E0000002_E0000001_E0000000);
    step();
    chk("t6i:en_off", 256'(mem_icache_return_data_en), 256'd0);
    chk("t6:d_next",  256'(mem_receive_dcache_read_ok), 256'd1);
    icache_read_mem_en = 1'b0; dcache_read_mem_en = 1'b0;
    step();
    icache_receive_mem_data_ok = 1'b0; dcache_receive_mem_data_ok = 1'b0;
    #1;
    chk("t6:d_ret_cycles", 256'(ret_d - rd0), 256'd1);
    chk("t6:i_ret_cycles", 256'(ret_i - ri0), 256'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
